// File: rtl/text_entry_scheduler_pkg.sv
// Shared types and constants for the text entry scheduler.
package text_pkg;

    // 5-bit letter code as carried on the display command interface
    typedef logic [4:0] letter_t;

    // Scroll direction; value 3 is reserved and passed through unchanged
    typedef enum logic [1:0] {
        DIR_NONE = 2'd0,
        DIR_UP   = 2'd1,
        DIR_DOWN = 2'd2,
        DIR_RSVD = 2'd3
    } scroll_dir_t;

    localparam int unsigned MAX_CODE_DEFAULT = 27;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_HOLDOFF
    } state_t;

endpackage

// File: rtl/text_entry_scheduler_arb.sv
// Two-way round-robin arbiter. The last-grant register starts at B so
// that A wins the first tie after reset.
module rr_arb2 (
    input  logic clk,
    input  logic rst_n,
    input  logic enable,
    input  logic req_a,
    input  logic req_b,
    output logic grant_a,
    output logic grant_b
);

    logic last_b;

    // Grant the requester that was not served last when both are asking
    always_comb begin
        grant_a = enable && req_a && (!req_b || last_b);
        grant_b = enable && req_b && (!req_a || !last_b);
    end

    // Remember which side was served most recently
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_b <= 1'b1;
        end else if (grant_a) begin
            last_b <= 1'b0;
        end else if (grant_b) begin
            last_b <= 1'b1;
        end
    end

endmodule

// File: rtl/text_entry_scheduler.sv
// Arbitrates letter requesters A/B and a scroll requester onto the display
// command port, issuing one-cycle strobes separated by a fixed hold-off gap.
module text_entry_scheduler
    import text_pkg::*;
#(
    parameter int unsigned GAP_CYCLES = 4,
    parameter int unsigned MAX_CODE   = MAX_CODE_DEFAULT
) (
    input  logic       clk_in,
    input  logic       rst_in,
    input  logic       a_valid_in,
    input  logic [4:0] a_data_in,
    output logic       a_ready_out,
    input  logic       b_valid_in,
    input  logic [4:0] b_data_in,
    output logic       b_ready_out,
    input  logic       scroll_valid_in,
    input  logic [1:0] scroll_dir_in,
    output logic       scroll_ready_out,
    output logic       data_valid_out,
    output logic [4:0] data_out,
    output logic [1:0] scroll_dir_out,
    output logic       busy_out,
    output logic [7:0] drop_count_out
);

    state_t     state, state_next;
    logic [7:0] cnt, cnt_next;
    letter_t    data_next;
    logic       dv_next;
    logic [1:0] dir_next;
    logic [7:0] drop_next;
    logic       idle;
    logic       grant_a, grant_b;
    letter_t    sel_code;

    assign idle = (state == ST_IDLE);

    // Scroll has strict priority, so letters only compete when no scroll is pending
    rr_arb2 u_arb (
        .clk     (clk_in),
        .rst_n   (rst_in),
        .enable  (idle && !scroll_valid_in),
        .req_a   (a_valid_in),
        .req_b   (b_valid_in),
        .grant_a (grant_a),
        .grant_b (grant_b)
    );

    // Handshake readies and the code of the granted letter
    always_comb begin
        a_ready_out      = grant_a;
        b_ready_out      = grant_b;
        scroll_ready_out = idle && scroll_valid_in;
        sel_code         = grant_a ? a_data_in : b_data_in;
        busy_out         = !idle;
    end

    // Next-state and next-output logic; strobes default low every cycle
    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        data_next  = data_out;
        dv_next    = 1'b0;
        dir_next   = DIR_NONE;
        drop_next  = drop_count_out;
        case (state)
            ST_IDLE: begin
                if (scroll_ready_out) begin
                    if (scroll_dir_in != DIR_NONE) begin
                        dir_next   = scroll_dir_in;
                        state_next = ST_ISSUE;
                    end
                end else if (grant_a || grant_b) begin
                    if (32'(sel_code) > MAX_CODE) begin
                        if (drop_count_out != 8'hFF) begin
                            drop_next = drop_count_out + 8'd1;
                        end
                    end else begin
                        dv_next    = 1'b1;
                        data_next  = sel_code;
                        state_next = ST_ISSUE;
                    end
                end
            end
            ST_ISSUE: begin
                cnt_next   = 8'(GAP_CYCLES - 1);
                state_next = ST_HOLDOFF;
            end
            ST_HOLDOFF: begin
                if (cnt == 8'd0) begin
                    state_next = ST_IDLE;
                end else begin
                    cnt_next = cnt - 8'd1;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // State, counter and registered display outputs
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            state          <= ST_IDLE;
            cnt            <= '0;
            data_valid_out <= 1'b0;
            data_out       <= '0;
            scroll_dir_out <= '0;
            drop_count_out <= '0;
        end else begin
            state          <= state_next;
            cnt            <= cnt_next;
            data_valid_out <= dv_next;
            data_out       <= data_next;
            scroll_dir_out <= dir_next;
            drop_count_out <= drop_next;
        end
    end

endmodule

// File: tb/tb_text_entry_scheduler.sv
// Scoreboard bench for text_entry_scheduler: stimulus pushes expected
// output events, a negedge monitor pops and compares them.
module tb_text_entry_scheduler;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       a_valid = 1'b0, b_valid = 1'b0, s_valid = 1'b0;
    logic [4:0] a_data = '0, b_data = '0;
    logic [1:0] s_dir = '0;
    logic       a_ready, b_ready, s_ready;
    logic       data_valid, busy;
    logic [4:0] data;
    logic [1:0] scroll_dir;
    logic [7:0] drop_count;

    typedef struct {
        bit          scroll;
        int unsigned val;
        int unsigned cyc;
    } exp_t;

    exp_t        expq[$];
    int unsigned cyc = 0;
    int          total = 0;
    int          passed = 0;
    int          rule_viol = 0;

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    text_entry_scheduler #(.GAP_CYCLES(4), .MAX_CODE(27)) dut (
        .clk_in           (clk),
        .rst_in           (rst),
        .a_valid_in       (a_valid),
        .a_data_in        (a_data),
        .a_ready_out      (a_ready),
        .b_valid_in       (b_valid),
        .b_data_in        (b_data),
        .b_ready_out      (b_ready),
        .scroll_valid_in  (s_valid),
        .scroll_dir_in    (s_dir),
        .scroll_ready_out (s_ready),
        .data_valid_out   (data_valid),
        .data_out         (data),
        .scroll_dir_out   (scroll_dir),
        .busy_out         (busy),
        .drop_count_out   (drop_count)
    );

    task automatic chk(input string name, input int unsigned act, input int unsigned exp);
        total++;
        if (act !== exp) begin
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end else begin
            passed++;
        end
    endtask

    function automatic void push_exp(input bit s, input int unsigned v, input int unsigned c);
        exp_t e;
        e.scroll = s;
        e.val    = v;
        e.cyc    = c;
        expq.push_back(e);
    endfunction

    // Monitor: every output pulse must match the head of the expected queue
    always @(negedge clk) begin
        if (rst) begin
            if ((int'(a_ready) + int'(b_ready) + int'(s_ready)) > 1) rule_viol++;
            if (busy && (a_ready || b_ready || s_ready)) rule_viol++;
            if (data_valid && scroll_dir != 2'd0) rule_viol++;
            if (data_valid || scroll_dir != 2'd0) begin
                if (expq.size() == 0) begin
                    chk("unexpected_output", 1, 0);
                end else begin
                    exp_t e;
                    e = expq.pop_front();
                    chk("out_kind", data_valid ? 0 : 1, e.scroll);
                    chk("out_val", data_valid ? data : scroll_dir, e.val);
                    chk("out_cycle", cyc, e.cyc);
                end
            end
        end
    end

    // Wait (bounded) for any ready; check who was granted and when
    task automatic wait_grant(input int exp_who, input int unsigned exp_cyc, input string name);
        bit got = 0;
        for (int i = 0; i < 40 && !got; i++) begin
            @(negedge clk);
            if (a_ready || b_ready || s_ready) begin
                got = 1;
                chk({name, "_who"}, s_ready ? 2 : (b_ready ? 1 : 0), exp_who);
                chk({name, "_cyc"}, cyc, exp_cyc);
            end
        end
        if (!got) chk({name, "_timeout"}, 0, 1);
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        rst = 1'b0;
        a_valid = 0; b_valid = 0; s_valid = 0;
        a_data = '0; b_data = '0; s_dir = '0;
        #1;
        chk("rst_dv", data_valid, 0);
        chk("rst_data", data, 0);
        chk("rst_dir", scroll_dir, 0);
        chk("rst_busy", busy, 0);
        chk("rst_drop", drop_count, 0);
        @(posedge clk);
        #1;
        rst = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int unsigned t0, t1;
        int          n;

        // Single letter from A, busy window length
        do_reset();
        a_valid = 1; a_data = 5; t0 = cyc;
        push_exp(0, 5, t0 + 1);
        wait_grant(0, t0, "t1_a");
        @(posedge clk); #1;
        a_valid = 0;
        n = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (busy) n++;
        end
        chk("t1_busy_cycles", n, 5);
        chk("t1_data_hold", data, 5);

        // A and B both continuously valid: alternate, 6 cycles apart
        do_reset();
        a_valid = 1; a_data = 1; b_valid = 1; b_data = 2; t0 = cyc;
        for (int k = 0; k < 4; k++) begin
            push_exp(0, (k % 2 == 0) ? 1 : 2, t0 + 6 * k + 1);
            wait_grant(k % 2, t0 + 6 * k, "t2_rr");
        end
        @(posedge clk); #1;
        a_valid = 0; b_valid = 0;

        // Scroll beats A in the same cycle; A follows after the gap
        do_reset();
        s_valid = 1; s_dir = 2; a_valid = 1; a_data = 7; t0 = cyc;
        push_exp(1, 2, t0 + 1);
        wait_grant(2, t0, "t3_scroll");
        @(posedge clk); #1;
        s_valid = 0; s_dir = 0;
        push_exp(0, 7, t0 + 7);
        wait_grant(0, t0 + 6, "t3_a");
        @(posedge clk); #1;
        a_valid = 0;

        // Out-of-range codes are dropped every cycle and the count saturates
        do_reset();
        b_valid = 1; b_data = 30; t0 = cyc;
        wait_grant(1, t0, "t4_drop");
        @(posedge clk); #1;
        chk("t4_drop_one", drop_count, 1);
        chk("t4_idle", busy, 0);
        n = 0;
        for (int i = 0; i < 259; i++) begin
            @(negedge clk);
            if (b_ready) n++;
        end
        chk("t4_accepts", n, 259);
        @(posedge clk); #1;
        b_valid = 0;
        chk("t4_drop_sat", drop_count, 255);

        // Scroll with direction 0 is consumed silently
        do_reset();
        s_valid = 1; s_dir = 0; t0 = cyc;
        wait_grant(2, t0, "t5_scroll0");
        @(posedge clk); #1;
        s_valid = 0;
        chk("t5_idle", busy, 0);
        a_valid = 1; a_data = 9; t1 = cyc;
        push_exp(0, 9, t1 + 1);
        wait_grant(0, t1, "t5_a");
        @(posedge clk); #1;
        a_valid = 0;

        // Reset during HOLDOFF clears outputs at once; A granted after release
        do_reset();
        a_valid = 1; a_data = 3; t0 = cyc;
        push_exp(0, 3, t0 + 1);
        wait_grant(0, t0, "t6_a");
        @(posedge clk); #1;
        a_data = 4;
        @(posedge clk);
        @(negedge clk);
        chk("t6_busy_before", busy, 1);
        rst = 1'b0;
        #1;
        chk("t6_rst_dv", data_valid, 0);
        chk("t6_rst_data", data, 0);
        chk("t6_rst_busy", busy, 0);
        chk("t6_rst_dir", scroll_dir, 0);
        @(posedge clk); #1;
        rst = 1'b1; t1 = cyc;
        push_exp(0, 4, t1 + 1);
        wait_grant(0, t1, "t6_after_rst");
        @(posedge clk); #1;
        a_valid = 0;

        repeat (10) @(posedge clk);
        chk("queue_empty", expq.size(), 0);
        chk("ready_rules", rule_viol, 0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
